mem_access_seq: RTL and testbench
=================================

Name: mem_access_seq

Overview:
Sequencer that runs one memory transaction at a time for the CPU datapath, on behalf of the control unit.
- Loads the MAR from the bus.
- Drives the memory read/write strobes and waits for memory ready.
- Steers the MDR input mux so read data is captured from memory (MDRread=1, MDRin=1).
- Reports completion or timeout to the control unit.

Sits between the control-unit FSM and the MAR/MDR/memory, and owns the MARin, MDRin and MDRread control lines during a transaction.

Parameters:
TIMEOUT, 8, max cycles spent in a wait state before aborting with err (legal range 1..2^CNT_W).
CNT_W, 4, width of the wait-cycle counter.

Ports:
clk  input  1  system clock; all state changes on rising edge
clr  input  1  synchronous active-high reset
rd_req  input  1  level request: read memory at the address on the bus; sampled only in IDLE
wr_req  input  1  level request: write current MDR contents to the address on the bus; sampled only in IDLE
mem_ready  input  1  memory acknowledges the current read/write; sampled only in RD_WAIT/WR_WAIT
MARin  output  1  load MAR from bus
MDRin  output  1  MDR load enable
MDRread  output  1  MDR mux select, 1 = memory data (mDataIn)
mem_rd  output  1  memory read strobe
mem_wr  output  1  memory write strobe
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse on successful completion
err  output  1  one-cycle pulse on timeout

Behaviour:
- Moore FSM. All outputs are decoded from the current state only (no input-to-output paths). Outputs not listed for a state are 0.
- States and outputs:
  - IDLE: none.
  - LOAD_MAR: MARin=1.
  - RD_WAIT: mem_rd=1.
  - RD_CAPTURE: MDRin=1, MDRread=1.
  - WR_WAIT: mem_wr=1.
  - DONE: done=1.
  - ERR: err=1.
  - busy=1 in every state except IDLE.
- Transitions (evaluated at each clk edge, clr not asserted):
  - IDLE: rd_req=1 -> LOAD_MAR, latch op=read. Else wr_req=1 -> LOAD_MAR, latch op=write. Else stay.
  - Simultaneous rd_req and wr_req in IDLE: read wins; the write is not queued and must still be asserted when the sequencer returns to IDLE.
  - LOAD_MAR -> RD_WAIT if op=read, WR_WAIT if op=write. Counter cleared to 0.
  - RD_WAIT/WR_WAIT:
    - mem_ready=1 -> RD_CAPTURE (read) or DONE (write).
    - Else counter==TIMEOUT-1 -> ERR.
    - Else counter+1 and stay.
    - mem_ready wins over timeout on the same edge.
  - RD_CAPTURE -> DONE.
  - DONE -> IDLE.
  - ERR -> IDLE.
- Requests are ignored while busy=1. A request held high through DONE/ERR starts a new transaction on the first IDLE edge, giving one IDLE cycle minimum between transactions.
- mem_ready outside the wait states has no effect.
- Latency (request sampled at edge E0, mem_ready already high):
  - Read: MARin in cycle 1, mem_rd cycle 2, MDRin/MDRread cycle 3, done cycle 4, IDLE cycle 5.
  - Write: MARin cycle 1, mem_wr cycle 2, done cycle 3.
  - Each extra wait cycle adds one.
- Timeout: with mem_ready never asserted, the strobe stays high exactly TIMEOUT cycles, then err pulses one cycle. No MDR load occurs on a read timeout.
- Counter width: CNT_W bits, no wrap inside a wait state (bounded by TIMEOUT).
- Reset: clr=1 at an edge forces IDLE, counter=0 and op=read. All outputs are 0 in the following cycle.
  - clr mid-transaction aborts with no done or err pulse.
  - clr dominates all other inputs.

Test Plan:
1. Reset then idle: clr=1 one edge, no requests for 5 cycles -> all outputs 0, busy=0.
2. Read, zero wait: rd_req=1 one cycle, mem_ready tied 1 -> MARin cycle 1, mem_rd cycle 2, MDRin=MDRread=1 cycle 3, done cycle 4, busy high cycles 1-4.
3. Write, 3 wait cycles: wr_req pulse, mem_ready rises on the 4th RD/WR_WAIT cycle -> mem_wr high exactly 4 cycles, MDRin never 1, done one cycle after, err=0.
4. Read timeout (TIMEOUT=8): rd_req pulse, mem_ready=0 -> mem_rd high exactly 8 cycles, then err=1 one cycle, MDRin never asserted, IDLE next.
5. Contention/priority: rd_req=wr_req=1 held continuously, mem_ready=1 -> read runs first (mem_rd, not mem_wr); after done, one IDLE cycle, then read runs again (wr starved, as specified).
6. Reset mid-op: start read, assert clr during the 2nd RD_WAIT cycle -> next cycle mem_rd=0, busy=0, no done/err pulse ever; a fresh wr_req then completes normally.

Source files
------------

// File: rtl/mem_access_seq.sv
// ============================================================================
// Module   : mem_access_seq
// Purpose  : Runs one MAR/MDR memory transaction at a time for the control
//            unit. It drives the strobes, waits for ready, and reports
//            done or err.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_seq #(
    parameter int TIMEOUT = 8,
    parameter int CNT_W   = 4
) (
    input  logic clk,
    input  logic clr,
    input  logic rd_req,
    input  logic wr_req,
    input  logic mem_ready,
    output logic MARin,
    output logic MDRin,
    output logic MDRread,
    output logic mem_rd,
    output logic mem_wr,
    output logic busy,
    output logic done,
    output logic err
);

    localparam logic [2:0] c_IDLE       = 3'd0;
    localparam logic [2:0] c_LOAD_MAR   = 3'd1;
    localparam logic [2:0] c_RD_WAIT    = 3'd2;
    localparam logic [2:0] c_RD_CAPTURE = 3'd3;
    localparam logic [2:0] c_WR_WAIT    = 3'd4;
    localparam logic [2:0] c_DONE       = 3'd5;
    localparam logic [2:0] c_ERR        = 3'd6;

    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [2:0]       r_state;
    logic [2:0]       w_state_next;
    logic             r_op_wr;
    logic             w_op_wr_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= c_IDLE;
            r_op_wr <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_op_wr <= w_op_wr_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_op_wr_next = r_op_wr;
        w_cnt_next   = r_cnt;
        case (r_state)
            c_IDLE: begin
                // Read has priority; a losing write is simply not queued.
                if (rd_req) begin
                    w_state_next = c_LOAD_MAR;
                    w_op_wr_next = 1'b0;
                end else if (wr_req) begin
                    w_state_next = c_LOAD_MAR;
                    w_op_wr_next = 1'b1;
                end
            end
            c_LOAD_MAR: begin
                w_cnt_next   = '0;
                w_state_next = r_op_wr ? c_WR_WAIT : c_RD_WAIT;
            end
            c_RD_WAIT, c_WR_WAIT: begin
                if (mem_ready) begin
                    w_state_next = (r_state == c_RD_WAIT) ? c_RD_CAPTURE : c_DONE;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_state_next = c_ERR;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            c_RD_CAPTURE: w_state_next = c_DONE;
            c_DONE:       w_state_next = c_IDLE;
            c_ERR:        w_state_next = c_IDLE;
            default:      w_state_next = c_IDLE;
        endcase
    end

    assign MARin   = (r_state == c_LOAD_MAR);
    assign mem_rd  = (r_state == c_RD_WAIT);
    assign MDRin   = (r_state == c_RD_CAPTURE);
    assign MDRread = (r_state == c_RD_CAPTURE);
    assign mem_wr  = (r_state == c_WR_WAIT);
    assign done    = (r_state == c_DONE);
    assign err     = (r_state == c_ERR);
    assign busy    = (r_state != c_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mem_access_seq.sv
// ============================================================================
// Module   : tb_mem_access_seq
// Purpose  : Directed self-checking bench for mem_access_seq.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access_seq;

    logic clk = 1'b0;
    logic clr, rd_req, wr_req, mem_ready;
    logic MARin, MDRin, MDRread, mem_rd, mem_wr, busy, done, err;

    int checks   = 0;
    int failures = 0;

    // Output vector: {MARin, MDRin, MDRread, mem_rd, mem_wr, busy, done, err}
    localparam logic [7:0] E_IDLE = 8'h00;
    localparam logic [7:0] E_LOAD = 8'h84;
    localparam logic [7:0] E_RDW  = 8'h14;
    localparam logic [7:0] E_CAP  = 8'h64;
    localparam logic [7:0] E_WRW  = 8'h0C;
    localparam logic [7:0] E_DONE = 8'h06;
    localparam logic [7:0] E_ERR  = 8'h05;

    mem_access_seq #(.TIMEOUT(8), .CNT_W(4)) dut (
        .clk       (clk),
        .clr       (clr),
        .rd_req    (rd_req),
        .wr_req    (wr_req),
        .mem_ready (mem_ready),
        .MARin     (MARin),
        .MDRin     (MDRin),
        .MDRread   (MDRread),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] expv);
        logic [7:0] obs;
        obs = {MARin, MDRin, MDRread, mem_rd, mem_wr, busy, done, err};
        checks++;
        assert (obs === expv)
        else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    initial begin
        clr = 1'b1; rd_req = 1'b0; wr_req = 1'b0; mem_ready = 1'b0;
        step();
        clr = 1'b0;
        chk("reset", E_IDLE);

        // Reset then idle; mem_ready toggling in IDLE must do nothing
        for (int i = 0; i < 5; i++) begin
            mem_ready = i[0];
            step();
            chk("idle", E_IDLE);
        end

        // Read, zero wait
        rd_req = 1'b1; mem_ready = 1'b1;
        step(); rd_req = 1'b0;
        chk("rd0_load", E_LOAD);
        step(); chk("rd0_wait", E_RDW);
        step(); chk("rd0_cap", E_CAP);
        step(); chk("rd0_done", E_DONE);
        step(); chk("rd0_idle", E_IDLE);

        // Write, ready on the 4th wait cycle
        mem_ready = 1'b0; wr_req = 1'b1;
        step(); wr_req = 1'b0;
        chk("wr3_load", E_LOAD);
        for (int i = 0; i < 4; i++) begin
            step(); chk("wr3_wait", E_WRW);
            if (i == 3) mem_ready = 1'b1;
        end
        step(); chk("wr3_done", E_DONE);
        mem_ready = 1'b0;
        step(); chk("wr3_idle", E_IDLE);

        // Read timeout: 8 strobe cycles then err, no capture
        rd_req = 1'b1;
        step(); rd_req = 1'b0;
        chk("to_load", E_LOAD);
        for (int i = 0; i < 8; i++) begin
            step(); chk("to_wait", E_RDW);
        end
        step(); chk("to_err", E_ERR);
        step(); chk("to_idle", E_IDLE);

        // Ready arriving on the last allowed wait cycle beats the timeout
        rd_req = 1'b1;
        step(); rd_req = 1'b0;
        chk("edge_load", E_LOAD);
        for (int i = 0; i < 8; i++) begin
            step(); chk("edge_wait", E_RDW);
        end
        mem_ready = 1'b1;
        step(); chk("edge_cap", E_CAP);
        mem_ready = 1'b0;
        step(); chk("edge_done", E_DONE);
        step(); chk("edge_idle", E_IDLE);

        // Contention: read wins both times, one IDLE cycle between
        rd_req = 1'b1; wr_req = 1'b1; mem_ready = 1'b1;
        step(); chk("pri_load1", E_LOAD);
        step(); chk("pri_wait1", E_RDW);
        step(); chk("pri_cap1", E_CAP);
        step(); chk("pri_done1", E_DONE);
        step(); chk("pri_idle", E_IDLE);
        step(); chk("pri_load2", E_LOAD);
        step(); chk("pri_wait2", E_RDW);
        rd_req = 1'b0; wr_req = 1'b0;
        step(); chk("pri_cap2", E_CAP);
        step(); chk("pri_done2", E_DONE);
        step(); chk("pri_idle2", E_IDLE);

        // Reset during the 2nd RD_WAIT cycle aborts silently
        mem_ready = 1'b0; rd_req = 1'b1;
        step(); rd_req = 1'b0;
        chk("rst_load", E_LOAD);
        step(); chk("rst_wait1", E_RDW);
        step(); chk("rst_wait2", E_RDW);
        clr = 1'b1;
        step(); clr = 1'b0;
        chk("rst_abort", E_IDLE);
        for (int i = 0; i < 10; i++) begin
            step(); chk("rst_quiet", E_IDLE);
        end
        wr_req = 1'b1; mem_ready = 1'b1;
        step(); wr_req = 1'b0;
        chk("post_load", E_LOAD);
        step(); chk("post_wait", E_WRW);
        step(); chk("post_done", E_DONE);
        step(); chk("post_idle", E_IDLE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
